// File: rtl/diff_frame_packer.sv
// Frame buffer and AXI-Stream serialiser for the XDMA C2H path: stores commit frames
// with a {A5, seq, drop_count} header and emits them as BEATS stream beats each.
module diff_frame_packer #(
  parameter int DATA_WIDTH = 4064,
  parameter int AXIS_WIDTH = 512,
  parameter int BEATS      = 8,
  parameter int DEPTH      = 2
) (
  input  logic                    xdma_clk,
  input  logic                    xdma_resetn,
  input  logic                    dma_enable,
  input  logic                    in_enable,
  input  logic [DATA_WIDTH-1:0]   in_io_data,
  output logic                    in_ready,
  output logic                    stall,
  output logic [AXIS_WIDTH-1:0]   m_axis_c2h_tdata,
  output logic [AXIS_WIDTH/8-1:0] m_axis_c2h_tkeep,
  output logic                    m_axis_c2h_tlast,
  output logic                    m_axis_c2h_tvalid,
  input  logic                    m_axis_c2h_tready,
  output logic [31:0]             frames_sent,
  output logic [15:0]             drop_count,
  output logic                    fsm_state
);

  // Entry width must equal BEATS * AXIS_WIDTH; DEPTH is a power of two >= 2.
  localparam int ENTRY_W = DATA_WIDTH + 32;
  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int BW      = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [7:0]      seq;
  logic            full, empty, push, drop, pop;
  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ENTRY_W-1:0]    head;
  logic [AXIS_WIDTH-1:0] head_beats [BEATS];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Admission looks only at registered occupancy: a pop in the same cycle never
  // frees a slot for the frame presented alongside it.
  assign in_ready = dma_enable && !full;
  assign stall    = full;
  assign push     = in_enable && in_ready;
  assign drop     = in_enable && dma_enable && full;

  // Stream handshake: a beat transfers on tvalid && tready. Once tvalid rises it
  // holds, with tdata/tlast/tkeep frozen, until that transfer happens.
  assign pop = (state_q == SEND) && m_axis_c2h_tready && (beat_q == LAST_BEAT);

  assign wr_ptr_nxt = wr_ptr + PW'(push);
  assign rd_ptr_nxt = rd_ptr + PW'(pop);

  always_ff @(posedge xdma_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {8'hA5, seq, drop_count, in_io_data};
  end

  assign head = mem[rd_ptr[AW-1:0]];

  for (genvar i = 0; i < BEATS; i++) begin : g_beats
    assign head_beats[i] = head[i*AXIS_WIDTH +: AXIS_WIDTH];
  end

  assign m_axis_c2h_tvalid = (state_q == SEND);
  assign m_axis_c2h_tdata  = (state_q == SEND) ? head_beats[beat_q] : '0;
  assign m_axis_c2h_tlast  = (state_q == SEND) && (beat_q == LAST_BEAT);
  assign m_axis_c2h_tkeep  = {(AXIS_WIDTH/8){m_axis_c2h_tvalid}};
  assign fsm_state         = state_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = SEND;
          beat_d  = '0;
        end
      end
      SEND: begin
        if (m_axis_c2h_tready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            // Staying in SEND when more is queued gives back-to-back frames.
            if (wr_ptr_nxt == rd_ptr_nxt) state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
    if (!xdma_resetn) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      seq         <= '0;
      drop_count  <= '0;
      frames_sent <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      if (push) seq <= seq + 8'd1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (pop) frames_sent <= frames_sent + 32'd1;
    end
  end

endmodule

// File: doc/diff_frame_packer.md
# diff_frame_packer

Buffers the wide per-cycle commit frames produced by the DUT wrapper (`out_enable` / `out_io_data`) and serialises them into 512-bit AXI-Stream beats for the XDMA C2H channel. Each frame carries a sequence and drop-count header so the host can detect loss. Sits in the `xdma_clk` domain between `dut_wrapper` and the C2H stream port of `pcie4_send`. It provides a full indication for DUT throttling and a frame-drop policy when throttling is not honoured.

## Interface
- `DATA_WIDTH`, 4064: frame payload width.
- `AXIS_WIDTH`, 512: stream beat width; `DATA_WIDTH + 32` must equal `BEATS * AXIS_WIDTH`.
- `BEATS`, 8: beats per frame.
- `DEPTH`, 2: frame buffer entries; power of two.

Ports:
- `xdma_clk`  in  1  sole clock.
- `xdma_resetn`  in  1  asynchronous, active-low reset.
- `dma_enable`  in  1  host enable for frame capture.
- `in_enable`  in  1  frame present this cycle.
- `in_io_data`  in  DATA_WIDTH  frame payload.
- `in_ready`  out  1  frame will be accepted if presented this cycle.
- `stall`  out  1  buffer full; throttle request to DUT.
- `m_axis_c2h_tdata`  out  AXIS_WIDTH  stream data.
- `m_axis_c2h_tkeep`  out  AXIS_WIDTH/8  byte enables.
- `m_axis_c2h_tlast`  out  1  last beat of frame.
- `m_axis_c2h_tvalid`  out  1  beat valid.
- `m_axis_c2h_tready`  in  1  beat accepted.
- `frames_sent`  out  32  count of frames whose last beat completed.
- `drop_count`  out  16  saturating count of dropped frames.

## Operation
- Buffer state: FIFO of `DEPTH` frames, each stored as `{header[31:0], payload}`. Write and read pointers are one bit wider than the index, so full and empty are distinguished.
- `in_ready = dma_enable && !full`, using the registered state only. There is no same-cycle bypass. If the buffer is full, a pop completing in the same cycle does not free a slot for that cycle's frame.
- `stall = full`.
- Accept: when `in_enable && in_ready`, the frame is written and `seq` increments by 1 (8-bit, wraps 255 -> 0).
- Header format: `{8'hA5, seq, drop_count}`. `seq` and `drop_count` are the values before the increment.
- Drop: when `in_enable && dma_enable && full`, the frame is discarded and `drop_count` increments. It saturates at 16'hFFFF.
- Frames presented while `dma_enable` is low are discarded and not counted.
- Dropping `dma_enable` does not cancel frames already buffered or in flight; they complete.
- Send state machine:
  - IDLE: `tvalid` = 0. If not empty, load the beat counter to 0 and go to SEND next cycle.
  - SEND: `tvalid` = 1. `tdata` = bits `[512k+511:512k]` of the head entry, where k is the beat counter. `tlast = (k == BEATS-1)`.
  - On `tvalid && tready` with k < BEATS-1: k increments.
  - On the last-beat handshake: pop the entry and increment `frames_sent` (wraps). If the FIFO is still non-empty after the pop, stay in SEND with k = 0. Otherwise go to IDLE.
- Beat stability: `tdata`, `tlast` and `tkeep` stay stable while `tvalid && !tready`. `tvalid` never deasserts without a handshake.
- `tkeep` is all ones whenever `tvalid` is high.
- Simultaneous push and pop: both happen in the same cycle, and occupancy is unchanged.

## Timing
- Reset (asynchronous, immediate): `tvalid` = 0, `tlast` = 0, `tdata` = 0, `tkeep` = 0, `frames_sent` = 0, `drop_count` = 0, `seq` = 0, FIFO empty, state IDLE.
- After reset, `in_ready` = `dma_enable` and `stall` = 0.
- Reset asserted mid-frame: the partial frame is abandoned and all buffered frames are lost.
- Latency: a frame accepted in cycle N with the FIFO empty and state IDLE gives beat 0 valid in cycle N+2. IDLE sees non-empty in N+1; SEND is entered in N+2.
- Back-to-back frames: with `tready` held high there is no bubble between the last beat of one frame and beat 0 of the next.
- Sustained throughput with `tready` high: 1 frame per `BEATS` cycles. Input faster than this fills the FIFO and then drops.
- Counter updates are visible the cycle after the triggering event.

## Test plan
- Single frame, `tready`=1: payload = incrementing bytes. Expect 8 beats starting 2 cycles after accept. Beat 7 bits [511:480] = 32'hA5000000. `tlast` only on beat 7. `frames_sent` = 1.
- Backpressure: toggle `tready` at random 50% duty during a frame. Expect `tdata` held constant while stalled, all 8 beats in order, no duplicates or loss.
- Overflow: `tready`=0, present 4 frames on consecutive cycles. Expect the first 2 accepted; `stall` = 1 from the cycle after the second accept; `drop_count` = 2. Release `tready`: frame headers show seq 0 and 1, and the second header carries drop_count 0.
- Push and pop at full: fill the FIFO, then present a frame in the same cycle as a last-beat handshake. Expect that frame dropped (`drop_count` +1), not accepted.
- Wrap and saturation: send 257 frames and check the last header's seq = 8'h00. Force 65540 drops and check `drop_count` = 16'hFFFF.
- Reset mid-frame and disable: assert `xdma_resetn` low at beat 3 and expect `tvalid` low immediately and all counters 0. With `dma_enable`=0, present 3 frames and expect no accept and `drop_count` = 0.
